// File: rtl/word_dispatch_1to4_pkg.sv
// Purpose: shared lane-count constants and the lane-select decode for the
//          1-to-4 word dispatcher and its lane buffers.
// Latency: none (constants and a combinational helper only).
// Backpressure: n/a.
package word_dispatch_1to4_pkg;

  // These values must match those used by the OR-tree recombiner so lane
  // numbering agrees on both sides.
  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;

  // One-hot select of the lane addressed by idx.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] idx);
    return NUM_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/word_dispatch_1to4_lane.sv
// Purpose: one-entry output buffer for a single dispatch lane.
// Latency: a word loaded in cycle n is presented in cycle n+1.
// Backpressure: holds its word while ready=0; a drain and reload in the same cycle keeps the lane full.
//
// Ports:
//   clk, rst_n, clr   clock, async active-low reset, sync clear
//   load, load_data   write the buffer from the dispatcher
//   ready             downstream accepts the held word
//   valid, data       buffer occupied / held word
module dispatch_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // Covers the drain-plus-reload case: the lane stays full with the new word.
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      // Data is left in place; only the occupancy flag drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_dispatch_1to4.sv
// Purpose: deals one valid/ready word stream round-robin onto four buffered lanes.
// Latency: one cycle from input accept to the lane's out_valid/out_data.
// Backpressure: in_ready depends only on the lane at lane_ptr; a stalled target lane blocks input.
//
// Ports:
//   clk, rst_n, clr            clock, async active-low reset, sync clear
//   in_valid/in_ready/in_data  upstream word stream
//   out_valid/out_ready        per-lane handshake, bit i = lane i
//   out_data                   lane i at out_data[i*WIDTH +: WIDTH]
//   lane_ptr                   lane that receives the next accepted word
//   busy                       any lane holds a word
module word_dispatch_1to4
  import word_dispatch_1to4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [LANE_IDX_W-1:0]      lane_ptr,
  output logic                       busy
);

  logic [LANE_IDX_W-1:0] ptr_q;
  logic                  acc;
  logic [NUM_LANES-1:0]  load;

  // Only the target lane's state feeds in_ready, so in_valid never reaches it
  // combinationally.
  assign in_ready = ~out_valid[ptr_q] | out_ready[ptr_q];

  // Clear wins over a same-cycle accept; the offered word is dropped.
  assign acc  = in_valid & in_ready & ~clr;
  assign load = acc ? lane_onehot(ptr_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (acc) begin
      // Natural wrap of the 2-bit index gives 3 -> 0.
      ptr_q <= ptr_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dispatch_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*WIDTH +: WIDTH])
    );
  end

  assign lane_ptr = ptr_q;
  assign busy     = |out_valid;

endmodule
